// File: rtl/up_sample_pkg.sv
// Shared types for the integer-factor upsampler.
package up_sample_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } up_state_t;

endpackage

// File: rtl/up_sample_fifo.sv
// Small synchronous FIFO built from flops; rdata always shows the head entry.
module up_sample_fifo
  import up_sample_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_en  = push && !full;
    pop_en   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_en) - CW'(pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/up_sample.sv
// Integer-factor upsampler: each input sample becomes UP_SAMPLING_TIME output strobes,
// either held (sample-and-hold) or zero-stuffed, paced every OUT_INTERVAL clocks.
module up_sample
  import up_sample_pkg::*;
#(
  parameter int UP_SAMPLING_TIME = 8,
  parameter int DIN_WIDTH        = 12,
  parameter int OUT_INTERVAL     = 1,
  parameter int ZERO_STUFF       = 0,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [DIN_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 starve
);

  localparam int PW = $clog2(UP_SAMPLING_TIME);
  localparam int TW = $clog2(OUT_INTERVAL+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  up_state_t            state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [DIN_WIDTH-1:0] hold_q, hold_d;
  logic [DIN_WIDTH-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 din_ready_q, din_ready_d;
  logic                 starve_q, starve_d;

  logic                 push, pop;
  logic [DIN_WIDTH-1:0] fifo_rdata;
  logic [CW-1:0]        fifo_count, count_next;
  logic                 fifo_full, fifo_empty;

  // Handshake: a sample transfers on any edge where din_valid and din_ready are both high.
  assign push = din_valid && din_ready_q && !fifo_full;

  up_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DIN_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (din),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tick_d       = tick_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    starve_d     = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_rdata;
          phase_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick_q == TW'(OUT_INTERVAL-1)) begin
          tick_d       = '0;
          dout_d       = ((ZERO_STUFF != 0) && (phase_q != '0)) ? '0 : hold_q;
          dout_valid_d = 1'b1;
          if (phase_q == PW'(UP_SAMPLING_TIME-1)) begin
            phase_d = '0;
            // Reload on the last phase so back-to-back inputs stream without a gap.
            if (!fifo_empty) begin
              pop    = 1'b1;
              hold_d = fifo_rdata;
            end else begin
              state_d  = IDLE;
              starve_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    count_next  = fifo_count + CW'(push) - CW'(pop);
    din_ready_d = (count_next < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      tick_q       <= '0;
      hold_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      tick_q       <= tick_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
      starve_q     <= starve_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign starve     = starve_q;

endmodule
